// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Contents:
//   fetch_state_e - fetch FSM states (idle, three byte fetches, hold)
//   BYTE_WIDTH    - width of one program-memory byte
//   INSTR_WIDTH   - width of a full instruction {opcode, operando1, operando2}
//   pack_instr    - builds the instruction word in the order the instruction register expects
package instruction_fetch_pkg;

  localparam int unsigned BYTE_WIDTH  = 8;
  localparam int unsigned INSTR_WIDTH = 3 * BYTE_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StFetchOp,
    StFetchA,
    StFetchB,
    StHold
  } fetch_state_e;

  function automatic logic [INSTR_WIDTH-1:0] pack_instr(
    input logic [BYTE_WIDTH-1:0] op,
    input logic [BYTE_WIDTH-1:0] a,
    input logic [BYTE_WIDTH-1:0] b
  );
    return {op, a, b};
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_counter.sv
// Program counter for the fetch unit.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset (loads RESET_PC)
//   inc       - advance by one byte, wrapping modulo 2^ADDR_WIDTH
//   load      - load load_addr (jump); takes priority over inc
//   load_addr - jump target
//   pc        - current program counter
module pc_counter #(
  parameter int unsigned                ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  output logic [ADDR_WIDTH-1:0] pc
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_addr;
    end else if (inc) begin
      // Natural overflow of the ADDR_WIDTH-bit sum gives the wrap to 0.
      pc_d = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Sequential three-byte instruction fetch from a byte-wide program memory.
// Ports:
//   clk, rst              - clock and asynchronous active-high reset
//   mem_addr, mem_rd      - read request to program memory (address = pc)
//   mem_data, mem_ready   - read data and completion strobe
//   opcode, operando1,
//   operando2             - fetched instruction bytes, each updated only by its own read
//   instr_valid           - a complete instruction is being presented
//   instr_ack             - consumer accepts the presented instruction
//   jump_en, jump_addr    - redirect applied only when the instruction is accepted
//   pc                    - address of the next byte to fetch
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [BYTE_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  output logic [BYTE_WIDTH-1:0] opcode,
  output logic [BYTE_WIDTH-1:0] operando1,
  output logic [BYTE_WIDTH-1:0] operando2,
  output logic                  instr_valid,
  input  logic                  instr_ack,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] pc
);

  fetch_state_e state_q, state_d;

  logic [BYTE_WIDTH-1:0] opcode_q, operando1_q, operando2_q;
  logic                  rd_done;
  logic                  accept;

  // A byte read completes only while a request is actually outstanding.
  assign rd_done = mem_rd & mem_ready;
  assign accept  = (state_q == StHold) & instr_ack;

  pc_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_counter (
    .clk       (clk),
    .rst       (rst),
    .inc       (rd_done),
    .load      (accept & jump_en),
    .load_addr (jump_addr),
    .pc        (pc)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    state_d = StFetchOp;
      StFetchOp: if (mem_ready) state_d = StFetchA;
      StFetchA:  if (mem_ready) state_d = StFetchB;
      StFetchB:  if (mem_ready) state_d = StHold;
      StHold:    if (instr_ack) state_d = StFetchOp;
      default:   state_d = StIdle;
    endcase
  end

  // Moore outputs
  always_comb begin
    mem_rd      = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      StFetchOp, StFetchA, StFetchB: mem_rd      = 1'b1;
      StHold:                        instr_valid = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr = pc;

  // Byte registers are not cleared between instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q    <= '0;
      operando1_q <= '0;
      operando2_q <= '0;
    end else if (mem_ready) begin
      case (state_q)
        StFetchOp: opcode_q    <= mem_data;
        StFetchA:  operando1_q <= mem_data;
        StFetchB:  operando2_q <= mem_data;
        default: ;
      endcase
    end
  end

  assign opcode    = opcode_q;
  assign operando1 = operando1_q;
  assign operando2 = operando2_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a per-cycle vector table for the main
// sequence, a second instance with RESET_PC=0xFE for address wrap, and a hand-written
// reset-during-fetch sequence.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] mem_addr, w_mem_addr;
  logic       mem_rd, w_mem_rd;
  logic [7:0] mem_data, w_mem_data;
  logic       mem_ready = 1'b0;
  logic [7:0] opcode, operando1, operando2;
  logic [7:0] w_opcode, w_operando1, w_operando2;
  logic       instr_valid, w_instr_valid;
  logic       instr_ack = 1'b0;
  logic       jump_en = 1'b0;
  logic [7:0] jump_addr = 8'h00;
  logic [7:0] pc, w_pc;

  logic [7:0] mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign mem_data   = mem[mem_addr];
  assign w_mem_data = mem[w_mem_addr];

  instruction_fetch #(
    .ADDR_WIDTH (8),
    .RESET_PC   (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .opcode      (opcode),
    .operando1   (operando1),
    .operando2   (operando2),
    .instr_valid (instr_valid),
    .instr_ack   (instr_ack),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .pc          (pc)
  );

  // Wrap instance: always-ready memory, never acknowledged, so it parks in hold.
  instruction_fetch #(
    .ADDR_WIDTH (8),
    .RESET_PC   (8'hFE)
  ) dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (w_mem_addr),
    .mem_rd      (w_mem_rd),
    .mem_data    (w_mem_data),
    .mem_ready   (1'b1),
    .opcode      (w_opcode),
    .operando1   (w_operando1),
    .operando2   (w_operando2),
    .instr_valid (w_instr_valid),
    .instr_ack   (1'b0),
    .jump_en     (1'b0),
    .jump_addr   (8'h00),
    .pc          (w_pc)
  );

  typedef struct {
    logic       ready;
    logic       ack;
    logic       jen;
    logic [7:0] jaddr;
    logic       rd;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] pc;
  } vec_t;

  localparam int NVec = 26;
  vec_t vecs [NVec];

  function automatic vec_t mk(input logic ready, input logic ack, input logic jen,
                              input logic [7:0] jaddr, input logic rd, input logic valid,
                              input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] pcv);
    vec_t v;
    v.ready = ready; v.ack = ack; v.jen = jen; v.jaddr = jaddr;
    v.rd = rd; v.addr = pcv; v.valid = valid;
    v.op = op; v.a = a; v.b = b; v.pc = pcv;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  logic [7:0] wrap_addr [3];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33;
    mem[8'h03] = 8'h44; mem[8'h04] = 8'h55; mem[8'h05] = 8'h66;
    mem[8'h40] = 8'hA1; mem[8'h41] = 8'hB2; mem[8'h42] = 8'hC3;
    mem[8'hFE] = 8'hE1; mem[8'hFF] = 8'hF2;
    wrap_addr[0] = 8'hFE; wrap_addr[1] = 8'hFF; wrap_addr[2] = 8'h00;

    // Each row: inputs driven before an edge, outputs expected just after it.
    //               rdy  ack  jen  jaddr  rd   vld  op     a      b      pc
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00); // idle->op
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 8'h01);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 8'h22, 8'h00, 8'h02);
    vecs[3]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 8'h22, 8'h33, 8'h03); // hold
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 8'h22, 8'h33, 8'h03); // acked
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h44, 8'h22, 8'h33, 8'h04);
    // Two wait cycles on operando1; jump pulsed outside hold must be ignored.
    vecs[6]  = mk(1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 8'h44, 8'h22, 8'h33, 8'h04);
    vecs[7]  = mk(1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 8'h44, 8'h22, 8'h33, 8'h04);
    vecs[8]  = mk(1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 8'h44, 8'h55, 8'h33, 8'h05);
    vecs[9]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 8'h55, 8'h66, 8'h06);
    // Back-pressure: five cycles without ack.
    vecs[10] = mk(1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 8'h44, 8'h55, 8'h66, 8'h06);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 8'h55, 8'h66, 8'h06);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 8'h55, 8'h66, 8'h06);
    vecs[13] = mk(1'b1, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 8'h44, 8'h55, 8'h66, 8'h06);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 8'h55, 8'h66, 8'h06);
    // Ack with jump to 0x40.
    vecs[15] = mk(1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 8'h44, 8'h55, 8'h66, 8'h40);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA1, 8'h55, 8'h66, 8'h41);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA1, 8'hB2, 8'h66, 8'h42);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 8'hB2, 8'hC3, 8'h43);
    // Jump to the top of memory: fetch wraps FF, 00, 01.
    vecs[19] = mk(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 8'hA1, 8'hB2, 8'hC3, 8'hFF);
    vecs[20] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hF2, 8'hB2, 8'hC3, 8'h00);
    vecs[21] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hF2, 8'h10, 8'hC3, 8'h01);
    vecs[22] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hF2, 8'h10, 8'h22, 8'h02);
    vecs[23] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hF2, 8'h10, 8'h22, 8'h02);
    vecs[24] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 8'h10, 8'h22, 8'h03);
    vecs[25] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 8'h44, 8'h22, 8'h04); // in F_B

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("rst_mem_rd", 0, 32'(mem_rd), 32'h0);
    check("rst_valid",  0, 32'(instr_valid), 32'h0);
    check("rst_addr",   0, 32'(mem_addr), 32'h00);
    check("rst_bytes",  0, {8'h00, opcode, operando1, operando2}, 32'h0);
    check("rst_w_addr", 0, 32'(w_mem_addr), 32'hFE);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_rd", 0, 32'(mem_rd), 32'h0);

    for (int i = 0; i < NVec; i++) begin
      mem_ready = vecs[i].ready;
      instr_ack = vecs[i].ack;
      jump_en   = vecs[i].jen;
      jump_addr = vecs[i].jaddr;
      @(posedge clk);
      #1;
      check("mem_rd",      i, 32'(mem_rd),      32'(vecs[i].rd));
      check("mem_addr",    i, 32'(mem_addr),    32'(vecs[i].addr));
      check("instr_valid", i, 32'(instr_valid), 32'(vecs[i].valid));
      check("opcode",      i, 32'(opcode),      32'(vecs[i].op));
      check("operando1",   i, 32'(operando1),   32'(vecs[i].a));
      check("operando2",   i, 32'(operando2),   32'(vecs[i].b));
      check("pc",          i, 32'(pc),          32'(vecs[i].pc));
      if (i < 3) begin
        check("wrap_rd",   i, 32'(w_mem_rd),   32'h1);
        check("wrap_addr", i, 32'(w_mem_addr), 32'(wrap_addr[i]));
      end
      if (i == 3) begin
        check("wrap_valid", i, 32'(w_instr_valid), 32'h1);
        check("wrap_pc",    i, 32'(w_pc), 32'h01);
        check("wrap_instr", i, {8'h00, w_opcode, w_operando1, w_operando2}, 32'h00E1F210);
      end
    end

    // Reset while fetching operando2: everything clears without waiting for a clock.
    rst = 1'b1;
    #1;
    check("midrst_rd",    0, 32'(mem_rd), 32'h0);
    check("midrst_valid", 0, 32'(instr_valid), 32'h0);
    check("midrst_bytes", 0, {8'h00, opcode, operando1, operando2}, 32'h0);
    check("midrst_pc",    0, 32'(pc), 32'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    instr_ack = 1'b0;
    jump_en   = 1'b0;
    #1;
    check("midrst_idle_rd", 0, 32'(mem_rd), 32'h0);
    @(posedge clk);
    #1;
    check("restart_rd",   0, 32'(mem_rd), 32'h1);
    check("restart_addr", 0, 32'(mem_addr), 32'h00);
    check("restart_w",    0, 32'(w_mem_addr), 32'hFE);
    @(posedge clk);
    #1;
    check("restart_op", 0, 32'(opcode), 32'h10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Sequential fetch unit that reads the three bytes of each instruction (opcode, operando1, operando2) from a byte-wide program memory. It presents them as one instruction to the instruction register and decode stage. It sits between program memory and the instruction register. It owns the program counter and supports a jump redirect at instruction boundaries.

## Interface
- ADDR_WIDTH, 8: program-memory address width; PC wraps modulo 2^ADDR_WIDTH
- RESET_PC, 0: PC value loaded on reset
- clk  input  1  system clock, rising edge
- rst  input  1  reset; one clock, asynchronous, active-high (fixed)
- mem_addr  output  ADDR_WIDTH  byte address to program memory
- mem_rd  output  1  read request; mem_addr stable while high
- mem_data  input  8  read data; valid when mem_ready high
- mem_ready  input  1  memory completes the current read this cycle
- opcode  output  8  fetched opcode byte
- operando1  output  8  fetched first operand byte
- operando2  output  8  fetched second operand byte
- instr_valid  output  1  opcode/operando1/operando2 hold a complete instruction
- instr_ack  input  1  consumer accepts instruction; meaningful only with instr_valid
- jump_en  input  1  redirect PC; sampled only on an accepted instruction
- jump_addr  input  ADDR_WIDTH  redirect target
- pc  output  ADDR_WIDTH  address of the next byte to fetch

## Operation
- States:
  - IDLE: post-reset, one cycle.
  - F_OP: fetch opcode.
  - F_A: fetch operando1.
  - F_B: fetch operando2.
  - HOLD: instruction presented.
- Transitions:
  - IDLE -> F_OP unconditionally.
  - F_OP -> F_A, F_A -> F_B and F_B -> HOLD, each on mem_ready.
  - HOLD -> F_OP on instr_ack.
- In F_OP, F_A and F_B:
  - mem_rd=1 and mem_addr=pc.
  - On mem_ready, mem_data is registered into the matching byte and pc increments by 1, wrapping from 2^ADDR_WIDTH-1 to 0.
  - Without mem_ready the state, pc and request hold for any number of wait cycles.
- In HOLD:
  - mem_rd=0 and instr_valid=1.
  - Outputs are stable until instr_ack.
- On instr_ack in HOLD:
  - If jump_en, pc <= jump_addr; otherwise pc is unchanged, already pointing at the next instruction.
- jump_en/jump_addr are ignored in all other cases.
- instr_ack outside HOLD is ignored.
- opcode/operando1/operando2 are not cleared between instructions. Each byte updates only when its own read completes.
- Reset values:
  - state=IDLE, pc=RESET_PC.
  - mem_rd=0, mem_addr=RESET_PC, instr_valid=0.
  - opcode=operando1=operando2=0.
- Reset asserted mid-fetch or in HOLD aborts immediately. The partial instruction is discarded and the next fetch restarts at RESET_PC.

## Timing
- mem_rd, mem_addr and instr_valid are Moore outputs decoded from registered state and pc; there is no combinational path from inputs.
- First mem_rd is in the second rising edge's cycle after rst deasserts; the IDLE cycle precedes it.
- Zero-wait memory (mem_ready tied high): one cycle per byte. instr_valid rises the cycle after the operando2 read completes. Throughput is 4 cycles per instruction with immediate ack.
- Each wait cycle on mem_ready adds exactly one cycle of latency.
- Acked instruction: instr_valid drops the next cycle, and mem_rd rises that same cycle with mem_addr = new pc, which is the jump target if jump_en.
- Jump targets near the top wrap: jump_addr=2^ADDR_WIDTH-1 fetches bytes at FF, 00 and 01 (ADDR_WIDTH=8).

## Structure
- Shared package entries:
  - fetch state enum with IDLE, F_OP, F_A, F_B, HOLD.
  - BYTE_WIDTH=8 and INSTR_WIDTH=24, with {opcode, operando1, operando2} as the instruction concatenation order used by the instruction register.
- One sub-module: pc_counter, covering load-on-jump, increment-with-wrap and reset to RESET_PC. The FSM and byte registers stay in instruction_fetch.

## Test plan
- Zero-wait fetch: memory 00:0x10, 01:0x22, 02:0x33, mem_ready=1, ack held high -> addresses 00,01,02 on consecutive cycles; opcode=0x10, operando1=0x22, operando2=0x33 with instr_valid on cycle 4; next mem_addr=03.
- Wait states: mem_ready low for 2 cycles on the operando1 read -> mem_addr=01 held 3 cycles, instr_valid 2 cycles later than zero-wait, same data.
- Back-pressure: instr_ack low for 5 cycles in HOLD -> instr_valid and all three bytes stable, mem_rd=0 throughout, no pc change.
- Jump: ack with jump_en=1, jump_addr=0x40 -> next mem_addr=0x40. Also jump_en=1 pulsed during F_A -> ignored, pc continues sequentially.
- Wrap: RESET_PC=0xFE, ADDR_WIDTH=8 -> fetch addresses FE, FF, 00; pc=01 in HOLD.
- Reset mid-fetch: rst asserted during F_B -> mem_rd=0, instr_valid=0 and bytes=0 immediately. After release, IDLE for one cycle, then fetch restarts at RESET_PC.
